ins_prefetch: RTL and testbench

INS_PREFETCH -- requirements
Module: ins_prefetch

---
 rtl/ins_prefetch.sv | 150 +++++++++++++++
 tb/tb_ins_prefetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_prefetch.sv
// Instruction prefetch buffer: streams consecutive words from instruction memory
// into a small FIFO and serves in-order core fetches, flushing on a redirect.
module ins_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        exIns_ren,
  input  logic [31:0] exIns_addr,
  output logic        exIns_valid,
  output logic [31:0] exIns_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        head_addr_q, head_addr_d;
  logic [31:0]        fetch_addr_q, fetch_addr_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        fifo_q [DEPTH];

  logic        addr_match;
  logic        hit;
  logic        redirect;
  logic        push;
  logic [31:0] redirect_addr;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^exIns_addr[1:0];

  // Request classification against the FIFO head
  assign addr_match    = (exIns_addr[31:2] == head_addr_q[31:2]);
  assign hit           = exIns_ren && (count_q != '0) && addr_match;
  assign redirect      = exIns_ren && !addr_match;
  assign redirect_addr = {exIns_addr[31:2], 2'b00};

  assign exIns_valid = hit;
  assign exIns_out   = hit ? fifo_q[rd_ptr_q] : 32'h0;
  assign mem_req     = (state_q != S_IDLE);
  assign mem_addr    = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    head_addr_d  = head_addr_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    push         = 1'b0;

    if (hit) begin
      count_d     = count_q - CNT_W'(1);
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      head_addr_d = head_addr_q + 32'd4;
    end

    if (redirect) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      head_addr_d  = redirect_addr;
      fetch_addr_d = redirect_addr;
    end

    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          state_d    = S_REQ;
          mem_addr_d = redirect_addr;
        end else if (count_q < CNT_W'(DEPTH)) begin
          state_d    = S_REQ;
          mem_addr_d = fetch_addr_q;
        end
      end

      S_REQ: begin
        if (mem_ack && redirect) begin
          mem_addr_d = redirect_addr;
        end else if (mem_ack) begin
          push         = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_W'(1);
          count_d      = count_d + CNT_W'(1);
          fetch_addr_d = fetch_addr_q + 32'd4;
          if (count_d < CNT_W'(DEPTH)) begin
            mem_addr_d = fetch_addr_d;
          end else begin
            state_d = S_IDLE;
          end
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end

      S_DISCARD: begin
        // Stale response is dropped; resume at the latest target
        if (mem_ack) begin
          state_d    = S_REQ;
          mem_addr_d = fetch_addr_d;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      head_addr_q  <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      mem_addr_q   <= RESET_PC;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= 32'h0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ins_prefetch.sv
// Directed bench for ins_prefetch: memory responder acks the cycle after a request
// is issued; delivered instructions are checked against a scoreboard queue.
module tb_ins_prefetch;

  logic        clk;
  logic        nrst;
  logic        exIns_ren;
  logic [31:0] exIns_addr;
  logic        exIns_valid;
  logic [31:0] exIns_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ack_log[$];
  bit ack_en = 1'b1;

  ins_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .nrst(nrst),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .exIns_valid(exIns_valid), .exIns_out(exIns_out),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges in the first cycle a request is visible
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = nrst && ack_en && mem_req;
      mem_rdata = mem_ack ? data_of(mem_addr) : 32'h0;
      if (mem_ack) ack_log.push_back(mem_addr);
    end
  end

  // Monitor: every delivered instruction must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && exIns_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got %h expected none", exIns_out);
        end else begin
          chk("exIns_out", exIns_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic core_read(input logic [31:0] a, output int stalls);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    exp_q.push_back(data_of(a));
    exIns_ren  = 1'b1;
    exIns_addr = a;
    while (!got && n < 40) begin
      @(negedge clk);
      if (exIns_valid) got = 1'b1;
      else n++;
      @(posedge clk);
      #2;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no valid expected valid for %h", a);
    end
    stalls = n;
  endtask

  task automatic idle(input int n);
    exIns_ren = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    exIns_ren = 1'b0;
    ack_en    = 1'b1;
    nrst      = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    ack_log.delete();
    nrst = 1'b1;
  endtask

  initial begin
    int st;
    int total;
    nrst       = 1'b0;
    exIns_ren  = 1'b0;
    exIns_addr = 32'h0;

    // Reset values
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(exIns_valid), 32'h0);
    chk("rst_out", exIns_out, 32'h0);

    // Priming after reset with no core reads
    do_reset();
    @(negedge clk);
    chk("first_cycle_mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    chk("first_req", 32'(mem_req), 32'h1);
    chk("first_req_addr", mem_addr, 32'h0);
    repeat (6) @(negedge clk);
    chk("prime_acks", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_log.size()) chk("prime_addr", ack_log[i], 32'(i * 4));
    end
    chk("prime_idle", 32'(mem_req), 32'h0);
    chk("prime_count", 32'(dut.count_q), 32'd4);

    // Streaming reads once primed
    @(posedge clk);
    #2;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      core_read(32'(i * 4), st);
      total += st;
    end
    idle(1);
    chk("stream_stalls", 32'(total), 32'd0);

    // Redirect while a request is pending without ack
    do_reset();
    repeat (8) @(posedge clk);
    #2;
    ack_en = 1'b0;
    ack_log.delete();
    core_read(32'h0, st);
    idle(1);
    fork
      core_read(32'h100, st);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("discard_req", 32'(mem_req), 32'h1);
          chk("discard_addr", mem_addr, 32'h10);
        end
        ack_en = 1'b1;
      end
    join
    core_read(32'h104, st);
    idle(1);
    chk("discard_log0", (ack_log.size() > 0) ? ack_log[0] : 32'hFFFF_FFFF, 32'h10);
    chk("discard_log1", (ack_log.size() > 1) ? ack_log[1] : 32'hFFFF_FFFF, 32'h100);

    // Redirect in the same cycle as mem_ack
    do_reset();
    @(posedge clk);
    #2;
    chk("redir_ack_present", 32'(mem_ack), 32'h1);
    chk("redir_ack_addr", mem_addr, 32'h0);
    fork
      core_read(32'h200, st);
      begin
        @(posedge clk);
        #3;
        chk("redir_next_addr", mem_addr, 32'h200);
        chk("redir_next_req", 32'(mem_req), 32'h1);
      end
    join
    idle(1);
    chk("redir_log1", (ack_log.size() > 1) ? ack_log[1] : 32'hFFFF_FFFF, 32'h200);

    // Core waits on the reset PC right after release
    do_reset();
    core_read(32'h0, st);
    chk("wait_stalls", 32'(st), 32'd2);
    core_read(32'h4, st);
    idle(1);

    // Address wrap at the top of memory
    do_reset();
    core_read(32'hFFFF_FFFC, st);
    core_read(32'h0, st);
    idle(1);

    // Asynchronous reset mid-request with two words buffered
    do_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("mid_count", 32'(dut.count_q), 32'd2);
    exIns_ren  = 1'b1;
    exIns_addr = 32'h0;
    #1;
    chk("mid_hit_valid", 32'(exIns_valid), 32'h1);
    chk("mid_hit_data", exIns_out, 32'hDEAD_BEEF);
    nrst = 1'b0;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'h0);
    chk("async_valid", 32'(exIns_valid), 32'h0);
    chk("async_out", exIns_out, 32'h0);
    chk("async_mem_addr", mem_addr, 32'h0);
    exIns_ren = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    ack_log.delete();
    nrst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("restart_log0", (ack_log.size() > 0) ? ack_log[0] : 32'hFFFF_FFFF, 32'h0);
    chk("restart_log1", (ack_log.size() > 1) ? ack_log[1] : 32'hFFFF_FFFF, 32'h4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
